// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches 16-bit words, issues them, and forms the next PC.
// Optional feature macro FETCH_ICOUNT_EN adds a 32-bit fired-instruction counter on port icount.
module instr_fetch_unit #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            exec_ready,
    output logic [15:0]     instr,
    output logic [3:0]      op,
    input  logic            JUMP,
    input  logic            BRANCH,
    output logic [PC_W-1:0] pc,
    output logic            busy
`ifdef FETCH_ICOUNT_EN
    ,
    output logic [31:0]     icount
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [15:0]     instr_reg;
    logic            imem_req_reg;
    logic            instr_valid_reg;
    logic            busy_reg;

    logic            fire;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] branch_off;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_branch;
    logic [PC_W-1:0] pc_next;

    // Jump target is zero-extended/truncated from instr[11:0]; branch offset is sign-extended from instr[5:0].
    genvar gi;
    generate
        for (gi = 0; gi < PC_W; gi++) begin : g_ext
            if (gi < 12) begin : g_jmp_bit
                assign jump_target[gi] = instr_reg[gi];
            end else begin : g_jmp_zero
                assign jump_target[gi] = 1'b0;
            end
            if (gi < 6) begin : g_off_bit
                assign branch_off[gi] = instr_reg[gi];
            end else begin : g_off_sign
                assign branch_off[gi] = instr_reg[5];
            end
        end
    endgenerate

    assign fire      = (state_reg == ISSUE) && instr_valid_reg && exec_ready;
    assign pc_seq    = pc_reg + PC_W'(1);
    assign pc_branch = pc_seq + branch_off;

    always_comb begin
        pc_next = pc_seq;
        if (JUMP) begin
            pc_next = jump_target;
        end else if (BRANCH) begin
            pc_next = pc_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= PC_W'(RESET_PC);
            instr_reg       <= 16'h0000;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) begin
                        state_reg    <= FETCH;
                        imem_req_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                FETCH: begin
                    // run is deliberately ignored here: an in-flight fetch always completes and issues.
                    if (imem_ack) begin
                        instr_reg       <= imem_rdata;
                        state_reg       <= ISSUE;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        pc_reg          <= pc_next;
                        instr_valid_reg <= 1'b0;
                        if (run) begin
                            state_reg    <= FETCH;
                            imem_req_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [31:0] icount_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icount_reg <= 32'd0;
        end else if (fire) begin
            icount_reg <= icount_reg + 32'd1;
        end
    end

    assign icount = icount_reg;
`endif

    assign imem_req    = imem_req_reg;
    assign imem_addr   = pc_reg;
    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;
    assign op          = instr_reg[15:12];
    assign pc          = pc_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, jump/branch/wrap next-PC, stalls, run/reset control.
// Define FETCH_ICOUNT_EN to also check the fired-instruction counter.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_ready;
    logic [15:0] instr;
    logic [3:0]  op;
    logic        JUMP;
    logic        BRANCH;
    logic [7:0]  pc;
    logic        busy;
`ifdef FETCH_ICOUNT_EN
    logic [31:0] icount;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .PC_W     (8),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .instr       (instr),
        .op          (op),
        .JUMP        (JUMP),
        .BRANCH      (BRANCH),
        .pc          (pc),
        .busy        (busy)
`ifdef FETCH_ICOUNT_EN
        ,
        .icount      (icount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; waits for imem_req, optionally withholds ack, then delivers word.
    task automatic do_fetch(input logic [15:0] word, input int delay, input logic [7:0] exp_addr);
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("stall_addr", 32'(imem_addr), 32'(exp_addr));
            chk("stall_valid", 32'(instr_valid), 32'd0);
        end
        imem_rdata = word;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        chk("issue_valid", 32'(instr_valid), 32'd1);
        chk("issue_instr", 32'(instr), 32'(word));
        chk("issue_op", 32'(op), 32'(word[15:12]));
        $display("FETCH addr=%02h word=%04h delay=%0d", exp_addr, word, delay);
    endtask

    // Entered at a negedge in ISSUE; holds exec_ready low for stall cycles, then fires.
    task automatic do_issue(input string tag, input logic j, input logic b, input int stall,
                            input logic [7:0] exp_pc);
        logic [15:0] held_instr;
        logic [7:0]  held_pc;
        held_instr = instr;
        held_pc    = pc;
        JUMP   = j;
        BRANCH = b;
        for (int i = 0; i < stall; i++) begin
            exec_ready = 1'b0;
            imem_ack   = 1'b1;
            imem_rdata = 16'hDEAD;
            @(negedge clk);
            chk("hold_instr", 32'(instr), 32'(held_instr));
            chk("hold_pc", 32'(pc), 32'(held_pc));
            chk("hold_valid", 32'(instr_valid), 32'd1);
        end
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        JUMP       = 1'b0;
        BRANCH     = 1'b0;
        chk(tag, 32'(pc), 32'(exp_pc));
        chk("fire_valid_drop", 32'(instr_valid), 32'd0);
        $display("ISSUE %s instr=%04h jump=%0b branch=%0b stall=%0d next_pc=%02h",
                 tag, held_instr, j, b, stall, pc);
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_rdata = 16'h0000;
        imem_ack   = 1'b0;
        exec_ready = 1'b0;
        JUMP       = 1'b0;
        BRANCH     = 1'b0;

        // T1 reset
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0000);
        $display("RESET pc=%02h req=%0b valid=%0b busy=%0b", pc, imem_req, instr_valid, busy);

        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_busy", 32'(busy), 32'd1);

        // T2 jump
        do_fetch(16'h702A, 0, 8'h00);
        do_issue("jump_2a", 1'b1, 1'b0, 0, 8'h2A);
        do_fetch(16'h7005, 0, 8'h2A);
        do_issue("jump_05", 1'b1, 1'b0, 0, 8'h05);

        // T3 branch backward, then not taken
        do_fetch(16'h803E, 0, 8'h05);
        do_issue("branch_back", 1'b0, 1'b1, 0, 8'h04);
        do_fetch(16'h7005, 0, 8'h04);
        do_issue("jump_05b", 1'b1, 1'b0, 0, 8'h05);
        do_fetch(16'h803E, 0, 8'h05);
        do_issue("branch_not_taken", 1'b0, 1'b0, 0, 8'h06);

        // T4 priority (jump beats branch), then wrap
        do_fetch(16'h70FF, 0, 8'h06);
        do_issue("jump_over_branch", 1'b1, 1'b1, 0, 8'hFF);
        do_fetch(16'h1234, 0, 8'hFF);
        do_issue("wrap", 1'b0, 1'b0, 0, 8'h00);

        // T5 stalls on both handshakes (ack pulses during ISSUE must be ignored)
        do_fetch(16'h2345, 3, 8'h00);
        do_issue("stall_seq", 1'b0, 1'b0, 2, 8'h01);
        do_fetch(16'h8005, 0, 8'h01);
        do_issue("branch_fwd", 1'b0, 1'b1, 0, 8'h07);

        // T6 run dropped during FETCH: instruction still issues, then IDLE
        run = 1'b0;
        do_fetch(16'h0000, 1, 8'h07);
        do_issue("run_stop", 1'b0, 1'b0, 0, 8'h08);
        chk("stop_req", 32'(imem_req), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_pc", 32'(pc), 32'h08);
`ifdef FETCH_ICOUNT_EN
        chk("icount_10", icount, 32'd10);
`endif

        // Reset mid-FETCH with a coincident ack
        run = 1'b1;
        @(negedge clk);
        chk("refetch_req", 32'(imem_req), 32'd1);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        rst_n      = 1'b1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", 32'(instr), 32'h0000);
        chk("midrst_pc", 32'(pc), 32'h00);
        chk("midrst_busy", 32'(busy), 32'd0);
`ifdef FETCH_ICOUNT_EN
        chk("icount_rst", icount, 32'd0);
`endif
        $display("MIDRESET req=%0b valid=%0b instr=%04h pc=%02h", imem_req, instr_valid, instr, pc);

        // Recovery after reset
        do_fetch(16'h0001, 0, 8'h00);
        do_issue("recover", 1'b0, 1'b0, 0, 8'h01);
`ifdef FETCH_ICOUNT_EN
        chk("icount_after", icount, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
